// File: rtl/plic_mt_core.sv
// plic_mt_core: multi-target PLIC with level/edge gateways, per-target
// priority arbitration, thresholds and claim/complete.
module plic_mt_core #(
   parameter int IRQ_NUM    = 32,
   parameter int TGT_NUM    = 2,
   parameter int PRIO_WIDTH = 4,
   parameter int ID_WIDTH   = $clog2(IRQ_NUM)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [IRQ_NUM-1:0] irq_i,
   input  logic               reg_we_i,
   input  logic               reg_re_i,
   input  logic [7:0]         reg_addr_i,
   input  logic [31:0]        reg_wdata_i,
   output logic [31:0]        reg_rdata_o,
   output logic [TGT_NUM-1:0] irq_o
);
   localparam logic [IRQ_NUM-1:0] ONE = IRQ_NUM'(1);
   logic [PRIO_WIDTH-1:0] prio [IRQ_NUM];
   logic [IRQ_NUM-1:0]    ie [TGT_NUM];
   logic [PRIO_WIDTH-1:0] thold [TGT_NUM];
   logic [PRIO_WIDTH-1:0] best_prio [TGT_NUM];
   logic [PRIO_WIDTH-1:0] arb_prio [TGT_NUM];
   logic [ID_WIDTH-1:0]   best_id [TGT_NUM];
   logic [ID_WIDTH-1:0]   arb_id [TGT_NUM];
   logic [ID_WIDTH-1:0]   claim_id, comp_id;
   logic [IRQ_NUM-1:0]    ip, infl, ebuf, trig, irq_q;
   logic [IRQ_NUM-1:0]    claim, comp, ev, pop, efree, lset, ip_n, ebuf_n, wmask;
   logic                  comp_wr, trig_wr;
   logic [31:0]           rdata;

   assign comp_id = reg_wdata_i[ID_WIDTH-1:0];
   assign wmask   = reg_wdata_i[IRQ_NUM-1:0] & ~ONE;
   assign comp_wr = reg_we_i && reg_addr_i[7:4] == 4'h7 && 32'(reg_addr_i[3:0]) < TGT_NUM;
   assign trig_wr = reg_we_i && reg_addr_i == 8'h41;

   always_comb begin
      claim_id = '0;
      for (int t = 0; t < TGT_NUM; t++)
         if (reg_re_i && reg_addr_i == 8'(8'h70 + t) && best_prio[t] > thold[t] && ip[best_id[t]])
            claim_id = best_id[t];
   end

   // A complete from any target retires the source; ids out of range shift to zero
   assign claim  = (ONE << claim_id) & ~ONE;
   assign comp   = comp_wr ? (ONE << comp_id) & ~ONE & infl : '0;
   assign ev     = trig & irq_i & ~irq_q;
   assign pop    = comp & ebuf & trig;
   assign efree  = ~ip & (~infl | comp) & ~pop;
   assign lset   = ~trig & irq_i & ~ip & ~infl;
   assign ip_n   = ~claim & (ip | pop | (ev & efree) | lset) & ~ONE;
   assign ebuf_n = ((ev & ~efree) | (ebuf & ~pop)) & ~ONE;

   // Strict > keeps the lowest id on priority ties
   always_comb begin
      for (int t = 0; t < TGT_NUM; t++) begin
         arb_prio[t] = '0;
         arb_id[t]   = '0;
         for (int s = 1; s < IRQ_NUM; s++)
            if (ip[s] && ie[t][s] && prio[s] > arb_prio[t]) begin
               arb_prio[t] = prio[s];
               arb_id[t]   = ID_WIDTH'(s);
            end
      end
   end

   always_comb begin
      rdata = '0;
      for (int s = 1; s < IRQ_NUM; s++)
         if (reg_addr_i == 8'(s)) rdata = 32'(prio[s]);
      if (reg_addr_i == 8'h40) rdata = 32'(ip);
      if (reg_addr_i == 8'h41) rdata = 32'(trig);
      for (int t = 0; t < TGT_NUM; t++) begin
         if (reg_addr_i == 8'(8'h50 + t)) rdata = 32'(ie[t]);
         if (reg_addr_i == 8'(8'h60 + t)) rdata = 32'(thold[t]);
         if (reg_addr_i == 8'(8'h70 + t)) rdata = 32'(claim_id);
      end
      reg_rdata_o = reg_re_i ? rdata : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ip    <= '0;
         infl  <= '0;
         ebuf  <= '0;
         trig  <= '0;
         irq_q <= '0;
         irq_o <= '0;
         for (int s = 0; s < IRQ_NUM; s++) prio[s] <= '0;
         for (int t = 0; t < TGT_NUM; t++) begin
            ie[t]        <= '0;
            thold[t]     <= '0;
            best_id[t]   <= '0;
            best_prio[t] <= '0;
         end
      end else begin
         ip    <= ip_n;
         infl  <= (infl & ~comp) | claim;
         irq_q <= irq_i;
         ebuf  <= trig_wr ? ebuf_n & wmask : ebuf_n;
         if (trig_wr) trig <= wmask;
         for (int s = 1; s < IRQ_NUM; s++)
            if (reg_we_i && reg_addr_i == 8'(s)) prio[s] <= reg_wdata_i[PRIO_WIDTH-1:0];
         for (int t = 0; t < TGT_NUM; t++) begin
            best_id[t]   <= arb_id[t];
            best_prio[t] <= arb_prio[t];
            irq_o[t]     <= arb_prio[t] > thold[t];
            if (reg_we_i && reg_addr_i == 8'(8'h50 + t)) ie[t] <= wmask;
            if (reg_we_i && reg_addr_i == 8'(8'h60 + t)) thold[t] <= reg_wdata_i[PRIO_WIDTH-1:0];
         end
      end
   end
endmodule
